wb_multi_counter: RTL and testbench
===================================

// Module: wb_multi_counter
// PURPOSE
//  Wishbone-slave bank of NUM_CH independent up-counters with compare and interrupt, inside the user project area.
//  Parametrised successor of the single fixed-width example counter, generalised in channel count, counter width and IO width.
//  Adds per-channel compare, auto-reload, sticky match status and an aggregated IRQ.
//  Exposes counts on the logic analyser and channel 0 on the IO pads.
// PARAMETERS
//  NUM_CH   4   counter channels, 1..8
//  WIDTH    32  counter/compare width in bits, 8..32
//  IO_W     16  io_out/io_oeb width, <= WIDTH
//  BASE_ADR 32'h3000_0000  Wishbone base; decode uses wbs_adr_i[31:8]
// PORTS
//  wb_clk_i     in   1      single clock
//  wb_rst_i     in   1      synchronous, active-high reset
//  wbs_cyc_i    in   1      Wishbone cycle
//  wbs_stb_i    in   1      Wishbone strobe
//  wbs_we_i     in   1      1 = write
//  wbs_sel_i    in   4      byte enables
//  wbs_adr_i    in   32     byte address
//  wbs_dat_i    in   32     write data
//  wbs_ack_o    out  1      transfer acknowledge
//  wbs_dat_o    out  32     read data
//  la_data_in   in   64     bit ch = synchronous clear request for channel ch
//  la_oenb      in   64     bit ch low enables la_data_in[ch]
//  la_data_out  out  64     {counts} packed LSB-first; truncated or zero-extended to 64
//  io_out       out  IO_W   channel 0 count[IO_W-1:0]
//  io_oeb       out  IO_W   constant 0 (all outputs)
//  irq          out  3      [0] = OR over ch of (MATCH & IRQ_EN); [2:1] = 0
// BEHAVIOUR
//  Register map: channel stride 0x10 at adr[7:4], selected by ch = adr[7:4] < NUM_CH.
//    0x0 COUNT   RW
//    0x4 CTRL    RW: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN
//    0x8 COMPARE RW
//    0xC STATUS  [0] MATCH, sticky, write-1-clear
//  Reset: all registers 0; outputs ack=0, dat_o=0, irq=0, la_data_out=0, io_out=0.
//  Handshake:
//    - Request = cyc&stb&!ack; ack pulses exactly one cycle later, dat_o valid with ack.
//    - Next ack possible two cycles after the previous one.
//    - Writes honour wbs_sel_i per byte; bits above WIDTH are ignored on write and read 0.
//    - Unmapped or out-of-range channel: ack still given, reads 0, writes dropped.
//  Counting, when EN=1, per tick:
//    - COUNT==COMPARE: set MATCH; COUNT <= AUTO_RELOAD ? 0 : COUNT+1.
//    - 2^WIDTH-1 wraps to 0 and sets nothing.
//  Priority on COUNT, same cycle: LA clear > WB write > increment.
//  Priority on MATCH, same cycle: set wins over write-1-clear.
//  irq is registered, one cycle after MATCH is set.
//  Reset asserted mid-transfer: ack drops next edge, no write takes effect.
// CONFIGURATION
//  PRESCALER_EN defined:
//    - CTRL[15:8] PRESC; channel ticks once every PRESC+1 enabled cycles.
//    - Prescale counter clears on EN=0 or on a CTRL write.
//  PRESCALER_EN undefined:
//    - CTRL[15:8] reads 0 and writes are ignored; tick every cycle.
// STRUCTURE
//  Package wb_counter_pkg: register offsets, CTRL/STATUS bit positions, ch_ctrl_t struct.
//  Sub-module wb_counter_channel: one counter/compare/status slice, instantiated NUM_CH times.
//  Top holds Wishbone decode, ack, read mux, LA/IO/IRQ packing.
// TESTING
//  1. Reset, then read all regs of ch0..3 -> all 0; ack exactly 1 cycle after stb.
//  2. ch1: COMPARE=5, CTRL=0x7 -> MATCH set on 6th tick, COUNT reloads to 0, irq[0]=1 next cycle; W1C STATUS -> irq 0.
//  3. ch0: COUNT=0xFFFF_FFFE, EN=1, no reload -> ...FFFF then 0, MATCH stays 0 (COMPARE=0x10).
//  4. Same cycle: la_oenb[2]=0, la_data_in[2]=1 and WB write COUNT=0x55 to ch2 -> COUNT=0.
//  5. sel=4'b0010, write 0xAABBCCDD to ch0 COMPARE (was 0) -> COMPARE=0x0000CC00; adr ch7 read -> 0 with ack.
//  6. PRESCALER_EN: PRESC=3, EN=1 -> COUNT increments every 4 cycles; io_out tracks ch0 low 16 bits.

Source files
------------

// File: rtl/wb_counter_pkg.sv
// Shared definitions for the Wishbone counter bank:
// register offsets, CTRL/STATUS bit positions, channel control struct.
package wb_counter_pkg;

  localparam logic [1:0] REG_COUNT = 2'd0;
  localparam logic [1:0] REG_CTRL  = 2'd1;
  localparam logic [1:0] REG_CMP   = 2'd2;
  localparam logic [1:0] REG_STAT  = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int STAT_MATCH  = 0;

  typedef struct packed {
    logic [7:0] presc;
    logic       irq_en;
    logic       reload;
    logic       en;
  } ch_ctrl_t;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old,
    input logic [31:0] dat,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ctrl_word(input ch_ctrl_t c);
    return {16'h0, c.presc, 5'h0, c.irq_en, c.reload, c.en};
  endfunction

endpackage

// File: rtl/wb_counter_channel.sv
// One counter/compare/status slice of the counter bank.
// PRESCALER_EN adds an 8-bit per-channel tick prescaler.
module wb_counter_channel
  import wb_counter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_count,
  input  logic             wr_ctrl,
  input  logic             wr_cmp,
  input  logic             wr_stat,
  input  logic [31:0]      wdata,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] cmp,
  output ch_ctrl_t         ctrl,
  output logic             match
);

  logic        tick;
  logic        hit;
  logic [31:0] cnt_m;
  logic [31:0] cmp_m;

  assign hit   = (count == cmp);
  assign cnt_m = byte_merge(32'(count), wdata, sel);
  assign cmp_m = byte_merge(32'(cmp), wdata, sel);

`ifdef PRESCALER_EN
  logic [7:0] pc;

  assign tick = ctrl.en && (pc == ctrl.presc);

  // prescale counter, restarts on disable, CTRL write or tick
  always_ff @(posedge clk) begin
    if (rst)
      pc <= '0;
    else if (!ctrl.en || wr_ctrl || tick)
      pc <= '0;
    else
      pc <= pc + 8'd1;
  end
`else
  assign tick = ctrl.en;
`endif

  // count: LA clear beats bus write beats increment
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (wr_count)
      count <= cnt_m[WIDTH-1:0];
    else if (tick)
      count <= (hit && ctrl.reload) ? '0 : count + 1'b1;
  end

  // compare register
  always_ff @(posedge clk) begin
    if (rst)
      cmp <= '0;
    else if (wr_cmp)
      cmp <= cmp_m[WIDTH-1:0];
  end

  // control register, byte-enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      if (sel[0]) begin
        ctrl.en     <= wdata[CTRL_EN];
        ctrl.reload <= wdata[CTRL_RELOAD];
        ctrl.irq_en <= wdata[CTRL_IRQ_EN];
      end
`ifdef PRESCALER_EN
      if (sel[1]) ctrl.presc <= wdata[15:8];
`endif
    end
  end

  // sticky match, set wins over write-1-clear
  always_ff @(posedge clk) begin
    if (rst)
      match <= 1'b0;
    else if (tick && hit)
      match <= 1'b1;
    else if (wr_stat && sel[0] && wdata[STAT_MATCH])
      match <= 1'b0;
  end

endmodule

// File: rtl/wb_multi_counter.sv
// Wishbone slave bank of NUM_CH up-counters with compare and IRQ.
// Optional feature macro: PRESCALER_EN (per-channel tick prescaler).
module wb_multi_counter
  import wb_counter_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          WIDTH    = 32,
  parameter int          IO_W     = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [63:0]     la_data_in,
  input  logic [63:0]     la_oenb,
  output logic [63:0]     la_data_out,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb,
  output logic [2:0]      irq
);

  localparam int PW = NUM_CH * WIDTH;

  logic             req;
  logic             hit;
  logic             wr;
  logic [3:0]       ch;
  logic [1:0]       rsel;
  logic [31:0]      rdata;
  logic             irq_q;
  logic [WIDTH-1:0] counts [NUM_CH];
  logic [WIDTH-1:0] cmps   [NUM_CH];
  ch_ctrl_t         ctrls  [NUM_CH];
  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] irq_src;
  logic [PW-1:0]    packed_cnt;
  logic [PW+63:0]   la_ext;

  assign req  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign ch   = wbs_adr_i[7:4];
  assign rsel = wbs_adr_i[3:2];
  assign hit  = (wbs_adr_i[31:8] == BASE_ADR[31:8]) &&
                (ch < 4'(NUM_CH));
  assign wr   = req & wbs_we_i & hit;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wsel;
    assign wsel = wr && (ch == 4'(g));

    wb_counter_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (wb_clk_i),
      .rst      (wb_rst_i),
      .clr      (la_data_in[g] & ~la_oenb[g]),
      .wr_count (wsel && rsel == REG_COUNT),
      .wr_ctrl  (wsel && rsel == REG_CTRL),
      .wr_cmp   (wsel && rsel == REG_CMP),
      .wr_stat  (wsel && rsel == REG_STAT),
      .wdata    (wbs_dat_i),
      .sel      (wbs_sel_i),
      .count    (counts[g]),
      .cmp      (cmps[g]),
      .ctrl     (ctrls[g]),
      .match    (match[g])
    );

    assign irq_src[g] = match[g] & ctrls[g].irq_en;
    assign packed_cnt[g*WIDTH +: WIDTH] = counts[g];
  end

  // read mux over the selected channel register
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hit && ch == 4'(i)) begin
        unique case (rsel)
          REG_COUNT: rdata = 32'(counts[i]);
          REG_CTRL:  rdata = ctrl_word(ctrls[i]);
          REG_CMP:   rdata = 32'(cmps[i]);
          REG_STAT:  rdata = 32'(match[i]);
        endcase
      end
    end
  end

  // single-cycle ack, registered read data and irq
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_q     <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= req ? rdata : '0;
      irq_q     <= |irq_src;
    end
  end

  assign la_ext      = {64'h0, packed_cnt};
  assign la_data_out = la_ext[63:0];
  assign io_out      = counts[0][IO_W-1:0];
  assign io_oeb      = '0;
  assign irq         = {2'b00, irq_q};

endmodule

// File: tb/tb_wb_multi_counter.sv
// Randomised bench for wb_multi_counter against a cycle model
// built from the register-map rules, plus directed scenarios.
module tb_wb_multi_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [63:0] la_in, la_oenb, la_out;
  logic [15:0] io_out, io_oeb;
  logic [2:0]  irq;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] m_cnt [4];
  logic [31:0] m_cmp [4];
  logic [31:0] m_ctl [4];
  bit          m_mat [4];
  int          m_pc  [4];
  bit          m_ack;
  bit          m_rd;
  bit          m_irq;
  logic [31:0] m_dat;

`ifdef PRESCALER_EN
  localparam logic [31:0] CTL_MASK = 32'h0000_FF07;
`else
  localparam logic [31:0] CTL_MASK = 32'h0000_0007;
`endif

  always #5 clk = ~clk;

  wb_multi_counter dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .la_data_in  (la_in),
    .la_oenb     (la_oenb),
    .la_data_out (la_out),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .irq         (irq)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
      input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = 0;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
    return (o & ~m) | (d & m);
  endfunction

  // advance model and DUT one clock, then compare outputs
  task automatic step();
    bit          req, hit, nirq, en, tick, wrc, clr, eq;
    int          c, r, presc;
    logic [31:0] rd, ncnt;
    req = cyc && stb && !m_ack;
    c   = int'(adr[7:4]);
    r   = int'(adr[3:2]);
    hit = (adr[31:8] == 24'h30_0000) && (c < 4);
    rd  = 0;
    if (hit) begin
      case (r)
        0: rd = m_cnt[c];
        1: rd = m_ctl[c];
        2: rd = m_cmp[c];
        default: rd = {31'b0, m_mat[c]};
      endcase
    end
    nirq = 0;
    for (int i = 0; i < 4; i++) nirq |= m_mat[i] && m_ctl[i][2];
    if (rst) begin
      m_ack = 0; m_dat = 0; m_irq = 0; m_rd = 0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0; m_cmp[i] = 0; m_ctl[i] = 0;
        m_mat[i] = 0; m_pc[i] = 0;
      end
    end else begin
      m_ack = req;
      m_rd  = req && !we;
      m_dat = req ? rd : 0;
      m_irq = nirq;
      for (int i = 0; i < 4; i++) begin
        en    = m_ctl[i][0];
        presc = int'(m_ctl[i][15:8]);
        tick  = en && (m_pc[i] == presc);
        wrc   = req && we && hit && (c == i);
        clr   = la_in[i] && !la_oenb[i];
        eq    = (m_cnt[i] == m_cmp[i]);
        ncnt  = m_cnt[i];
        if (clr) ncnt = 0;
        else if (wrc && r == 0) ncnt = merge(m_cnt[i], wdat, sel);
        else if (tick) ncnt = (eq && m_ctl[i][1]) ? 0 : m_cnt[i] + 1;
        if (tick && eq) m_mat[i] = 1;
        else if (wrc && r == 3 && sel[0] && wdat[0]) m_mat[i] = 0;
        if (!en || (wrc && r == 1) || tick) m_pc[i] = 0;
        else m_pc[i] = m_pc[i] + 1;
        if (wrc && r == 1)
          m_ctl[i] = merge(m_ctl[i], wdat, sel) & CTL_MASK;
        if (wrc && r == 2) m_cmp[i] = merge(m_cmp[i], wdat, sel);
        m_cnt[i] = ncnt;
      end
    end
    @(posedge clk);
    #1;
    check("ack", ack, m_ack);
    check("irq", irq, {2'b00, m_irq});
    check("io_out", io_out, m_cnt[0][15:0]);
    check("la_out", la_out, {m_cnt[1], m_cnt[0]});
    if (m_ack && m_rd) check("dat", rdat, m_dat);
  endtask

  task automatic wb(input bit w, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] s);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    step();
    cyc = 0; stb = 0; we = 0;
    step();
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] exp,
                         input string tag);
    cyc = 1; stb = 1; we = 0; adr = a; wdat = 0; sel = 4'hF;
    step();
    check(tag, rdat, exp);
    cyc = 0; stb = 0;
    step();
  endtask

  initial begin
    rst = 1; cyc = 0; stb = 0; we = 0; sel = 0;
    adr = 0; wdat = 0; la_in = 0; la_oenb = '1;
    m_ack = 0;
    repeat (3) step();
    rst = 0;
    step();
    check("rst_ack", ack, 0);
    check("rst_irq", irq, 0);
    check("rst_la", la_out, 0);
    check("rst_io", io_out, 0);
    check("io_oeb", io_oeb, 0);

    // all registers of ch0..3 read zero after reset
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        wb_read(32'h3000_0000 | (c << 4) | (r << 2), 0, "rst_reg");

    // byte-lane write to ch0 COMPARE; channel 7 reads zero
    wb(1, 32'h3000_0008, 32'hAABB_CCDD, 4'b0010);
    wb_read(32'h3000_0008, 32'h0000_CC00, "sel_cmp");
    wb_read(32'h3000_0070, 0, "ch7_rd");

    // ch1 compare 5, reload, irq
    wb(1, 32'h3000_0018, 5, 4'hF);
    wb(1, 32'h3000_0014, 7, 4'hF);
    repeat (10) step();
    check("ch1_irq", irq, 3'b001);
    wb(1, 32'h3000_0014, 4, 4'hF);
    wb_read(32'h3000_0014, 4, "ch1_ctrl");
    wb_read(32'h3000_001C, 1, "ch1_match");
    wb(1, 32'h3000_001C, 1, 4'hF);
    step();
    check("ch1_w1c_irq", irq, 0);
    wb_read(32'h3000_001C, 0, "ch1_w1c");

    // LA clear beats bus write on ch2
    wb(1, 32'h3000_0020, 32'h77, 4'hF);
    la_oenb = ~64'h4; la_in = 64'h4;
    wb(1, 32'h3000_0020, 32'h55, 4'hF);
    la_oenb = '1; la_in = 0;
    wb_read(32'h3000_0020, 0, "la_clr");

    // ch0 wrap from all-ones, compare never hit
    wb(1, 32'h3000_0008, 32'h10, 4'hF);
    wb(1, 32'h3000_0000, 32'hFFFF_FFFE, 4'hF);
    wb(1, 32'h3000_0004, 1, 4'hF);
    check("wrap_ff", io_out, 16'hFFFF);
    step();
    check("wrap_0", la_out[31:0], 0);
    wb_read(32'h3000_000C, 0, "wrap_nomatch");
    wb(1, 32'h3000_0004, 0, 4'hF);

    // reset during a write request: no write, ack drops
    cyc = 1; stb = 1; we = 1; adr = 32'h3000_0030;
    wdat = 32'h99; sel = 4'hF; rst = 1;
    step();
    check("rst_mid_ack", ack, 0);
    cyc = 0; stb = 0; we = 0; rst = 0;
    step();
    wb_read(32'h3000_0030, 0, "rst_mid_wr");

`ifdef PRESCALER_EN
    wb(1, 32'h3000_0000, 0, 4'hF);
    wb(1, 32'h3000_0004, 32'h0301, 4'hF);
    repeat (20) step();
    wb(1, 32'h3000_0004, 0, 4'hF);
`endif

    // randomised traffic
    for (int n = 0; n < 300; n++) begin
      int c, r;
      logic [31:0] a, d;
      logic [3:0]  s;
      c = $urandom_range(0, 5);
      r = $urandom_range(0, 3);
      a = (($urandom_range(0, 9) == 0) ? 32'h3000_0100 : 32'h3000_0000)
          | (c << 4) | (r << 2);
      if (r == 1)
        d = ($urandom_range(0, 2) << 8) | $urandom_range(0, 7);
      else if (r == 3)
        d = $urandom;
      else
        d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 12);
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 19) == 0) begin
        la_in = 64'($urandom_range(0, 15));
        la_oenb = ~64'($urandom_range(0, 15));
      end else begin
        la_in = 0;
        la_oenb = '1;
      end
      wb($urandom_range(0, 1) == 1, a, d, s);
      la_in = 0;
      la_oenb = '1;
      repeat ($urandom_range(0, 3)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
